// File: rtl/addsub_arbiter_pkg.sv
// addsub_arbiter_pkg
// Shared definitions for the add/subtract arbiter:
//   - state_t : controller states (IDLE, EXEC, RESP)
//   - OPW     : operand / result width (16)
//   - SAT_MAX : largest signed 16-bit value, used on positive overflow
//   - SAT_MIN : smallest signed 16-bit value, used on negative overflow
//   - saturate(): clamps a wrapped adder result when overflow occurred
package addsub_arbiter_pkg;

  localparam int OPW = 16;

  localparam logic [OPW-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [OPW-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Signed overflow can only happen when both effective operands share a
  // sign, and that sign is always the sign of A, so A's sign bit alone tells
  // which rail to clamp to.
  function automatic logic [OPW-1:0] saturate(input logic [OPW-1:0] raw,
                                               input logic           ovfl,
                                               input logic           a_sign);
    logic [OPW-1:0] result;
    result = raw;
    if (ovfl) begin
      result = a_sign ? SAT_MIN : SAT_MAX;
    end
    return result;
  endfunction

endpackage

// File: rtl/addsub_16bit_cla.sv
// addsub_16bit_cla
// 16-bit two's complement adder/subtractor built as four 4-bit carry
// lookahead groups with a lookahead carry chain between groups.
// Ports:
//   Sum  output [15:0]  wrapped (non-saturated) A+B or A-B
//   Ovfl output         signed overflow of the wrapped result
//   A    input  [15:0]  operand A
//   B    input  [15:0]  operand B
//   Sub  input          1 = A-B, 0 = A+B
module addsub_16bit_cla (
  output logic [15:0] Sum,
  output logic        Ovfl,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Sub
);

  logic [15:0] b_eff;
  logic [15:0] gen;
  logic [15:0] prop;
  logic [16:0] carry;
  logic [4:0]  group_carry;
  logic        group_gen;
  logic        group_prop;

  // Subtraction is A + ~B + 1: invert B and feed Sub in as carry-in.
  // Group generate/propagate produce the carry into each 4-bit group, then
  // each group ripples internally from its own lookahead carry.
  always_comb begin
    b_eff          = B ^ {16{Sub}};
    gen            = A & b_eff;
    prop           = A ^ b_eff;
    group_carry    = '0;
    group_carry[0] = Sub;
    carry          = '0;
    group_gen      = 1'b0;
    group_prop     = 1'b0;

    for (int j = 0; j < 4; j++) begin
      group_gen  = 1'b0;
      group_prop = 1'b1;
      for (int b = 0; b < 4; b++) begin
        group_gen  = gen[4*j+b] | (prop[4*j+b] & group_gen);
        group_prop = group_prop & prop[4*j+b];
      end
      group_carry[j+1] = group_gen | (group_prop & group_carry[j]);
    end

    for (int j = 0; j < 4; j++) begin
      carry[4*j] = group_carry[j];
      for (int b = 0; b < 4; b++) begin
        carry[4*j+b+1] = gen[4*j+b] | (prop[4*j+b] & carry[4*j+b]);
      end
    end
    carry[16] = group_carry[4];

    Sum  = prop ^ carry[15:0];
    Ovfl = carry[16] ^ carry[15];
  end

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter
// Shares one 16-bit saturating adder/subtractor between NUM_REQ requesters.
// A three-state controller (IDLE -> EXEC -> RESP) grants one requester,
// computes its result in the shared adder and holds the response until the
// consumer accepts it.
//
// Configuration macro:
//   ADDSUB_ARB_RR_EN defined   : round-robin arbitration starting at a pointer
//                                that moves past each granted requester.
//   ADDSUB_ARB_RR_EN undefined : fixed priority, lowest index wins.
//
// Ports:
//   clk         input                 clock, rising edge
//   rst         input                 asynchronous active-high reset
//   req_valid   input  [NUM_REQ-1:0]  per-requester request valid
//   req_ready   output [NUM_REQ-1:0]  accept strobe, one-hot or zero
//   req_a       input  [16*NUM_REQ-1:0] operand A, requester i at [16i+15:16i]
//   req_b       input  [16*NUM_REQ-1:0] operand B, same packing
//   req_sub     input  [NUM_REQ-1:0]  1 = A-B, 0 = A+B
//   resp_valid  output                result available
//   resp_ready  input                 consumer accepts result
//   resp_id     output [1:0]          requester owning the result
//   resp_sum    output [15:0]         saturated signed result
//   resp_ovfl   output                result was saturated
//   ovfl_cnt    output [15:0]         saturating count of delivered overflows
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [OPW*NUM_REQ-1:0] req_a,
  input  logic [OPW*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]     req_sub,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [1:0]             resp_id,
  output logic [OPW-1:0]         resp_sum,
  output logic                   resp_ovfl,
  output logic [15:0]            ovfl_cnt
);

  state_t         state;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic           op_sub;
  logic [1:0]     op_id;

  logic           grant_any;
  logic [1:0]     grant_id;
  logic [OPW-1:0] sel_a;
  logic [OPW-1:0] sel_b;
  logic           sel_sub;

  logic [OPW-1:0] cla_sum;
  logic           cla_ovfl;

`ifdef ADDSUB_ARB_RR_EN
  logic [1:0]     ptr;

  // Round-robin search in two passes: first requesters at or above the
  // pointer, then the ones below it, which is a rotation without modulo.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[i] && (2'(i) >= ptr)) begin
        grant_any = 1'b1;
        grant_id  = 2'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[i] && (2'(i) < ptr)) begin
        grant_any = 1'b1;
        grant_id  = 2'(i);
      end
    end
  end
`else
  // Fixed priority: the lowest-numbered valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant_any = 1'b1;
        grant_id  = 2'(i);
      end
    end
  end
`endif

  // Pick the granted requester's operands out of the packed input buses.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 2'(i)) begin
        sel_a   = req_a[i*OPW +: OPW];
        sel_b   = req_b[i*OPW +: OPW];
        sel_sub = req_sub[i];
      end
    end
  end

  // Accept strobe only exists in IDLE; gating with rst keeps it low while
  // reset is held even though the state register already reads IDLE.
  always_comb begin
    req_ready = '0;
    if (!rst && (state == IDLE) && grant_any) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_id == 2'(i));
      end
    end
  end

  addsub_16bit_cla u_cla (
    .Sum  (cla_sum),
    .Ovfl (cla_ovfl),
    .A    (op_a),
    .B    (op_b),
    .Sub  (op_sub)
  );

  // Controller: IDLE latches the granted request, EXEC captures the
  // saturated adder output, RESP holds the response until it is taken.
  // Reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_sub     <= 1'b0;
      op_id      <= 2'd0;
      resp_valid <= 1'b0;
      resp_id    <= 2'd0;
      resp_sum   <= '0;
      resp_ovfl  <= 1'b0;
      ovfl_cnt   <= '0;
`ifdef ADDSUB_ARB_RR_EN
      ptr        <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_sub <= sel_sub;
            op_id  <= grant_id;
            state  <= EXEC;
`ifdef ADDSUB_ARB_RR_EN
            ptr    <= (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
`endif
          end
        end
        EXEC: begin
          resp_sum   <= saturate(cla_sum, cla_ovfl, op_a[OPW-1]);
          resp_ovfl  <= cla_ovfl;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
            if (resp_ovfl && (ovfl_cnt != 16'hFFFF)) begin
              ovfl_cnt <= ovfl_cnt + 16'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter
// Scoreboard bench for addsub_arbiter (NUM_REQ = 2). Stimulus pushes the
// hand-computed response into a queue when a request is granted; a monitor
// pops and compares whenever a response is handed over. Arbitration order
// expectations follow ADDSUB_ARB_RR_EN.
module tb_addsub_arbiter;

  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] sum;
    logic        ovfl;
  } exp_t;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_sub;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [1:0]           resp_id;
  logic [15:0]          resp_sum;
  logic                 resp_ovfl;
  logic [15:0]          ovfl_cnt;

  exp_t scoreboard[$];
  int   nChecks = 0;
  int   nFail   = 0;
  int   expCnt  = 0;

  addsub_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_ovfl  (resp_ovfl),
    .ovfl_cnt   (ovfl_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    nChecks++;
    nFail++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Wait (bounded) for requester id to see its accept strobe at a negedge.
  task automatic waitGrant(input int id, output bit ok);
    ok = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportTimeout("grant_wait");
  endtask

  // Issue one request, push its expected response on grant, and optionally
  // check the two-cycle gap between the grant cycle and resp_valid.
  task automatic applyStimulus(input int id, input logic [15:0] a,
                               input logic [15:0] b, input logic sub,
                               input logic [15:0] expSum, input logic expOvfl,
                               input bit checkLatency);
    bit ok;
    @(posedge clk); #1;
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_sub[id]        = sub;
    req_valid[id]      = 1'b1;
    waitGrant(id, ok);
    if (ok) begin
      scoreboard.push_back('{id: 2'(id), sum: expSum, ovfl: expOvfl});
      if (expOvfl) expCnt++;
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (ok && checkLatency) begin
      @(negedge clk);
      checkOutput("lat_exec_no_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      checkOutput("lat_resp_valid", 32'(resp_valid), 32'd1);
    end
  endtask

  // Wait (bounded) until every expected response has been delivered.
  task automatic drain();
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (scoreboard.size() == 0 && !resp_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) reportTimeout("drain");
  endtask

  // Monitor: every accepted response must match the oldest expectation;
  // a response with nothing expected is itself an error.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (scoreboard.size() == 0) begin
        reportTimeout("unexpected_response");
      end else begin
        exp_t e;
        e = scoreboard.pop_front();
        checkOutput("resp_id",   32'(resp_id),   32'(e.id));
        checkOutput("resp_sum",  32'(resp_sum),  32'(e.sum));
        checkOutput("resp_ovfl", 32'(resp_ovfl), 32'(e.ovfl));
      end
    end
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main stimulus sequence.
  initial begin
    bit ok;
    rst        = 1'b1;
    req_valid  = '1;
    req_a      = {16'h1111, 16'h2222};
    req_b      = {16'h3333, 16'h4444};
    req_sub    = '0;
    resp_ready = 1'b1;

    // Reset state, with requests pending to show they are not accepted.
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready",  32'(req_ready),  32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_id",    32'(resp_id),    32'd0);
    checkOutput("rst_resp_sum",   32'(resp_sum),   32'd0);
    checkOutput("rst_resp_ovfl",  32'(resp_ovfl),  32'd0);
    checkOutput("rst_ovfl_cnt",   32'(ovfl_cnt),   32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b0;

    // Directed arithmetic vectors.
    applyStimulus(0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b1);
    applyStimulus(1, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    drain();
    checkOutput("ovfl_cnt_first", 32'(ovfl_cnt), 32'd1);
    applyStimulus(0, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0);
    applyStimulus(0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    applyStimulus(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0);
    applyStimulus(0, 16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    applyStimulus(1, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b0);
    applyStimulus(0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    applyStimulus(1, 16'h8000, 16'h7FFF, 1'b1, 16'h8000, 1'b1, 1'b0);
    drain();
    checkOutput("ovfl_cnt_total", 32'(ovfl_cnt), 32'(expCnt));

    // Back-pressure: response must hold and no new grant may appear.
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_a[15:0] = 16'h0010;
    req_b[15:0] = 16'h0020;
    req_sub[0]  = 1'b0;
    req_valid[0] = 1'b1;
    waitGrant(0, ok);
    if (ok) scoreboard.push_back('{id: 2'd0, sum: 16'h0030, ovfl: 1'b0});
    @(posedge clk); #1;
    req_valid = '0;
    ok = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportTimeout("stall_resp_wait");
    @(posedge clk); #1;
    req_valid = '1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      checkOutput("stall_resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("stall_resp_sum",   32'(resp_sum),   32'h0030);
      checkOutput("stall_resp_id",    32'(resp_id),    32'd0);
      checkOutput("stall_req_ready",  32'(req_ready),  32'd0);
    end
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    drain();

    // Arbitration with both requesters continuously valid, from a fresh
    // reset so the round-robin pointer starts at requester 0.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    expCnt = 0;
    req_a   = {16'h0002, 16'h0001};
    req_b   = {16'h0003, 16'h0001};
    req_sub = '0;
    req_valid = '1;
    for (int g = 0; g < 4; g++) begin
      int expId;
`ifdef ADDSUB_ARB_RR_EN
      expId = g % 2;
`else
      expId = 0;
`endif
      ok = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        reportTimeout("arb_grant_wait");
        break;
      end
      checkOutput("arb_grant", 32'(req_ready), 32'(1 << expId));
      scoreboard.push_back('{id: 2'(expId), sum: (expId == 1) ? 16'h0005 : 16'h0002,
                             ovfl: 1'b0});
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    drain();

    // Reset while EXEC: the in-flight operation must vanish.
    @(posedge clk); #1;
    req_a[15:0] = 16'h7FFF;
    req_b[15:0] = 16'h7FFF;
    req_valid[0] = 1'b1;
    waitGrant(0, ok);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    checkOutput("exec_rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("exec_rst_resp_sum",   32'(resp_sum),   32'd0);
    checkOutput("exec_rst_resp_id",    32'(resp_id),    32'd0);
    checkOutput("exec_rst_resp_ovfl",  32'(resp_ovfl),  32'd0);
    checkOutput("exec_rst_ovfl_cnt",   32'(ovfl_cnt),   32'd0);
    checkOutput("exec_rst_req_ready",  32'(req_ready),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checkOutput("exec_rst_no_resp", 32'(resp_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
